// File: rtl/romulus_key_ctrl.sv
// Romulus key controller: loads the key from SDI into the datapath key register and handles ACTKEY.
// Optional header length check: define ROMULUS_KEY_LEN_CHECK_EN.
module romulus_key_ctrl #(
   parameter int BUSW     = 32,
   parameter int KEYBYTES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BUSW-1:0] sdi_data,
   input  logic            sdi_valid,
   output logic            sdi_ready,
   output logic [BUSW-1:0] key_data,
   output logic [1:0]      key_addr,
   output logic            key_we,
   output logic            key_valid,
   input  logic            actkey_req,
   output logic            actkey_ack,
   output logic            key_update,
   output logic            busy,
   output logic            err
);

   localparam int         NW       = KEYBYTES / (BUSW / 8);
   localparam logic [1:0] LAST     = 2'(NW - 1);
   localparam logic [3:0] OP_LDKEY = 4'h4;
   localparam logic [3:0] HDR_KEY  = 4'hC;

   typedef enum logic [1:0] {S_INST, S_HDR, S_KEY, S_DRAIN} state_t;

   state_t     state, state_n;
   logic [1:0] cnt, cnt_n;
   logic       accept, wr_key, hdr_err, ack_n, ack_hold;
`ifdef ROMULUS_KEY_LEN_CHECK_EN
   logic [14:0] drain, drain_n;
`endif

   assign sdi_ready = !rst;
   assign accept    = sdi_valid && sdi_ready;
   assign busy      = (state != S_INST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INST;
         cnt   <= '0;
`ifdef ROMULUS_KEY_LEN_CHECK_EN
         drain <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
`ifdef ROMULUS_KEY_LEN_CHECK_EN
         drain <= drain_n;
`endif
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_key  = 1'b0;
      hdr_err = 1'b0;
`ifdef ROMULUS_KEY_LEN_CHECK_EN
      drain_n = drain;
`endif
      case (state)
         S_INST: begin
            if (accept && sdi_data[31:28] == OP_LDKEY) state_n = S_HDR;
         end
         S_HDR: begin
            if (accept) begin
               if (sdi_data[31:28] != HDR_KEY) begin
                  hdr_err = 1'b1;
                  state_n = S_INST;
`ifdef ROMULUS_KEY_LEN_CHECK_EN
               end else if (sdi_data[15:0] != 16'(KEYBYTES)) begin
                  hdr_err = 1'b1;
                  drain_n = 15'(({1'b0, sdi_data[15:0]} + 17'd3) >> 2);
                  state_n = (sdi_data[15:0] == 16'd0) ? S_INST : S_DRAIN;
`endif
               end else begin
                  state_n = S_KEY;
                  cnt_n   = '0;
               end
            end
         end
         S_KEY: begin
            if (accept) begin
               wr_key = 1'b1;
               if (cnt == LAST) begin
                  state_n = S_INST;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 2'd1;
               end
            end
         end
         S_DRAIN: begin
`ifdef ROMULUS_KEY_LEN_CHECK_EN
            if (accept) begin
               drain_n = drain - 15'd1;
               if (drain == 15'd1) state_n = S_INST;
            end
`else
            state_n = S_INST;
`endif
         end
         default: state_n = S_INST;
      endcase
   end

   // One ack per request: ack_hold blocks re-acking until the decoder drops the level.
   assign ack_n = actkey_req && key_valid && (state == S_INST || state == S_HDR)
                  && !actkey_ack && !ack_hold;

   // NOTE: key_data is reset too, so a stale key word never appears on the bus after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_we     <= 1'b0;
         key_data   <= '0;
         key_addr   <= '0;
         key_valid  <= 1'b0;
         actkey_ack <= 1'b0;
         key_update <= 1'b0;
         ack_hold   <= 1'b0;
         err        <= 1'b0;
      end else begin
         key_we <= wr_key;
         if (wr_key) begin
            key_data <= sdi_data;
            key_addr <= cnt;
         end
         if (wr_key && cnt == 2'd0)             key_valid <= 1'b0;
         else if (key_we && key_addr == LAST)   key_valid <= 1'b1;
         if (hdr_err) err <= 1'b1;
         actkey_ack <= ack_n;
         key_update <= ack_n;
         if (!actkey_req) ack_hold <= 1'b0;
         else if (ack_n)  ack_hold <= 1'b1;
      end
   end

endmodule

// File: tb/tb_romulus_key_ctrl.sv
// Self-checking bench for romulus_key_ctrl: directed scenarios plus randomized key loads.
module tb_romulus_key_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] sdi_data = '0;
   logic        sdi_valid = 1'b0;
   logic        sdi_ready;
   logic [31:0] key_data;
   logic [1:0]  key_addr;
   logic        key_we, key_valid;
   logic        actkey_req = 1'b0;
   logic        actkey_ack, key_update, busy, err;

   romulus_key_ctrl #(.BUSW(32), .KEYBYTES(16)) dut (
      .clk(clk), .rst(rst), .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
      .key_data(key_data), .key_addr(key_addr), .key_we(key_we), .key_valid(key_valid),
      .actkey_req(actkey_req), .actkey_ack(actkey_ack), .key_update(key_update),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   logic [33:0] wr_log[$];
   int          ack_cnt = 0, ack_cyc = -1, kv_rise_cyc = -1, wr3_cyc = -1;
   logic        kv_prev = 1'b0;
   logic [31:0] key_w[4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Observer: logs key writes, ack pulses and key_valid rising edges.
   always @(negedge clk) begin
      if (key_we) begin
         wr_log.push_back({key_addr, key_data});
         if (key_addr == 2'd3) wr3_cyc = cyc;
      end
      if (actkey_ack) begin
         ack_cnt++;
         ack_cyc = cyc;
      end
      if (key_valid && !kv_prev) kv_rise_cyc = cyc;
      kv_prev = key_valid;
      check("upd_eq_ack", key_update, actkey_ack);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [31:0] w);
      check("sdi_ready", sdi_ready, 1);
      sdi_data  = w;
      sdi_valid = 1'b1;
      @(negedge clk);
      sdi_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      sdi_valid  = 1'b0;
      actkey_req = 1'b0;
      @(negedge clk);
      check("rst_ready", sdi_ready, 0);
      check("rst_outs", {key_we, key_addr, key_data, key_valid, actkey_ack, key_update, err, busy}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_post_rst", sdi_ready, 1);
   endtask

   task automatic rand_key();
      for (int i = 0; i < 4; i++) key_w[i] = $urandom;
   endtask

   // LDKEY + KEY header (length 16), then the four words with random idle gaps.
   task automatic do_load(input bit with_req, input bit gaps);
      send({4'h4, 28'($urandom)});
      send({4'hC, 12'($urandom), 16'h0010});
      if (with_req) actkey_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (gaps) idle($urandom_range(0, 2));
         send(key_w[i]);
      end
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwr"}, wr_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < wr_log.size())
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], {2'(i), key_w[i]});
      check({tag, "_kv"}, key_valid, 1);
      check({tag, "_kv_lat"}, kv_rise_cyc, wr3_cyc + 1);
   endtask

   int base, req_cyc;
   bit with_req;
   logic [31:0] junk;

   initial begin
      @(negedge clk);
      do_reset();

      // Reference stream from the Romulus example.
      key_w = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
      wr_log.delete();
      send(32'h40000000);
      send(32'hC2000010);
      check("busy_loading", busy, 1);
      for (int i = 0; i < 4; i++) send(key_w[i]);
      idle(3);
      check_writes("dir");
      check("dir_busy", busy, 0);
      check("dir_err", err, 0);

      // ACTKEY with key present: one ack next cycle, held level gives no second.
      base = ack_cnt;
      actkey_req = 1'b1;
      req_cyc = cyc;
      idle(6);
      check("ack_once", ack_cnt, base + 1);
      check("ack_lat", ack_cyc, req_cyc + 1);
      actkey_req = 1'b0;
      idle(2);

      // ACTKEY before any key: pending until load completes.
      do_reset();
      base = ack_cnt;
      actkey_req = 1'b1;
      idle(5);
      check("no_ack_nokey", ack_cnt, base);
      rand_key();
      wr_log.delete();
      do_load(1'b0, 1'b1);
      idle(4);
      check_writes("pend");
      check("pend_ack", ack_cnt, base + 1);
      check("pend_ack_lat", ack_cyc, kv_rise_cyc + 1);
      actkey_req = 1'b0;
      idle(1);

      // Bad header type: sticky err, back to instruction decode, key kept.
      wr_log.delete();
      send(32'h40000000);
      send(32'h52000010);
      idle(2);
      check("badhdr_err", err, 1);
      check("badhdr_busy", busy, 0);
      check("badhdr_kv", key_valid, 1);
      send(32'hC2000010);
      send(32'h11111111);
      idle(2);
      check("badhdr_nowr", wr_log.size(), 0);
      check("badhdr_busy2", busy, 0);

      // Short header length 8.
      do_reset();
      wr_log.delete();
      send(32'h40000000);
      send(32'hC2000008);
      send(32'hA0A1A2A3);
      send(32'hB0B1B2B3);
      idle(2);
`ifdef ROMULUS_KEY_LEN_CHECK_EN
      check("len_err", err, 1);
      check("len_nowr", wr_log.size(), 0);
      check("len_busy", busy, 0);
      rand_key();
      wr_log.delete();
      do_load(1'b0, 1'b0);
      idle(3);
      check_writes("len_next");
`else
      check("len_nwr2", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         check("len_wr0", wr_log[0], {2'd0, 32'hA0A1A2A3});
         check("len_wr1", wr_log[1], {2'd1, 32'hB0B1B2B3});
      end
      check("len_busy", busy, 1);
      check("len_kv0", key_valid, 0);
      key_w = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
      send(key_w[2]);
      send(key_w[3]);
      idle(3);
      check_writes("len_rest");
      check("len_err", err, 0);
`endif

      // Reset mid-load abandons the key, then a full load works.
      do_reset();
      rand_key();
      send(32'h40000000);
      send(32'hC2000010);
      send(key_w[0]);
      send(key_w[1]);
      do_reset();
      check("midrst_kv", key_valid, 0);
      rand_key();
      wr_log.delete();
      do_load(1'b0, 1'b0);
      idle(3);
      check_writes("midrst");

      // Randomized loads with junk instructions, gaps and optional ACTKEY.
      for (int it = 0; it < 20; it++) begin
         repeat ($urandom_range(0, 3)) begin
            junk = $urandom;
            if (junk[31:28] == 4'h4) junk[31] = 1'b1;
            send(junk);
         end
         rand_key();
         with_req = 1'($urandom_range(0, 1));
         base = ack_cnt;
         wr_log.delete();
         do_load(with_req, 1'b1);
         idle(4);
         check_writes($sformatf("rnd%0d", it));
         check("rnd_err", err, 0);
         check("rnd_busy", busy, 0);
         if (with_req) begin
            check("rnd_ack", ack_cnt, base + 1);
            check("rnd_ack_lat", ack_cyc, kv_rise_cyc + 1);
            actkey_req = 1'b0;
            idle(1);
         end else begin
            check("rnd_noack", ack_cnt, base);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
